// File: rtl/fb_pkg.sv
// Shared constants and types for the SPI-LCD framebuffer write path.
package fb_pkg;

  localparam int DEF_H_RES = 135;
  localparam int DEF_V_RES = 240;
  localparam int DEF_DW    = 24;
  localparam int DEF_AW    = $clog2(DEF_H_RES * DEF_V_RES);

  localparam logic MODE_FILL   = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic       mode;
    logic [7:0] x;
    logic [7:0] y;
    logic [8:0] w;
    logic [8:0] h;
  } cmd_geom_t;

  function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Column/row walker for a rectangle: incremental row base, in-bounds and last-pixel flags.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter int AW    = $clog2(H_RES * V_RES)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [AW-1:0] i_base,
  input  logic [7:0]    i_x,
  input  logic [7:0]    i_y,
  input  logic [8:0]    i_w,
  input  logic [8:0]    i_h,
  output logic [AW-1:0] o_addr,
  output logic [AW-1:0] o_next_addr,
  output logic          o_inb,
  output logic          o_last
);

  logic [8:0]    r_col;
  logic [8:0]    r_row;
  logic [AW-1:0] r_row_base;
  logic          w_eol;
  logic [9:0]    w_scr_x;
  logic [9:0]    w_scr_y;

  assign w_eol       = (r_col == i_w - 9'd1);
  assign o_last      = w_eol && (r_row == i_h - 9'd1);
  assign o_addr      = r_row_base + AW'(r_col);
  // Look-ahead address lets the fill path keep its output register one pixel ahead.
  assign o_next_addr = w_eol ? (r_row_base + AW'(H_RES)) : (o_addr + AW'(1));

  assign w_scr_x = {2'b00, i_x} + {1'b0, r_col};
  assign w_scr_y = {2'b00, i_y} + {1'b0, r_row};
  assign o_inb   = (w_scr_x < 10'(H_RES)) && (w_scr_y < 10'(V_RES));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (i_load) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= i_base;
    end else if (i_step) begin
      if (w_eol) begin
        r_col      <= '0;
        r_row      <= r_row + 9'd1;
        r_row_base <= r_row_base + AW'(H_RES);
      end else begin
        r_col <= r_col + 9'd1;
      end
    end
  end

endmodule

// File: rtl/fb_writer.sv
// Rectangle writer for the LCD framebuffer BRAM: solid fill or pixel stream, clipped to screen.
//   state    | meaning
//   IDLE     | waiting for a command, cmd_ready high
//   SETUP    | base multiply, clipping, reject decision
//   WRITE    | walking the rectangle (fill or stream)
//   DONE     | done pulse (stream holds one extra cycle for its last write)
module fb_writer
  import fb_pkg::*;
#(
  parameter  int H_RES = DEF_H_RES,
  parameter  int V_RES = DEF_V_RES,
  parameter  int DW    = DEF_DW,
  localparam int AW    = $clog2(H_RES * V_RES)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_mode,
  input  logic [7:0]      i_cmd_x,
  input  logic [7:0]      i_cmd_y,
  input  logic [8:0]      i_cmd_w,
  input  logic [8:0]      i_cmd_h,
  input  logic [DW-1:0]   i_cmd_color,
  input  logic            i_pix_valid,
  output logic            o_pix_ready,
  input  logic [DW-1:0]   i_pix_data,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_sel,
  output logic            o_mem_we,
  output logic            o_busy,
  output logic            o_done
);

  logic [1:0]      r_state;
  cmd_geom_t       r_cmd;
  logic [DW-1:0]   r_color;
  logic [8:0]      r_ew;
  logic [8:0]      r_eh;
  logic            r_drain;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW/8-1:0] r_mem_sel;

  logic            w_fill;
  logic [AW-1:0]   w_base;
  logic [8:0]      w_x_room;
  logic [8:0]      w_y_room;
  logic            w_degen;
  logic            w_reject;
  logic            w_pix_hs;
  logic            w_gen_load;
  logic            w_gen_step;
  logic [8:0]      w_gen_w;
  logic [8:0]      w_gen_h;
  logic [AW-1:0]   w_gen_addr;
  logic [AW-1:0]   w_gen_next;
  logic            w_gen_inb;
  logic            w_gen_last;

  assign w_fill   = (r_cmd.mode == MODE_FILL);
  assign w_base   = AW'((32'(r_cmd.y) * 32'(H_RES)) + 32'(r_cmd.x));
  assign w_x_room = 9'(H_RES) - {1'b0, r_cmd.x};
  assign w_y_room = 9'(V_RES) - {1'b0, r_cmd.y};
  assign w_degen  = (r_cmd.w == 9'd0) || (r_cmd.h == 9'd0);
  assign w_reject = w_degen || ({1'b0, r_cmd.x} >= 9'(H_RES)) || ({1'b0, r_cmd.y} >= 9'(V_RES));

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE) && !r_drain;
  assign o_pix_ready = (r_state == ST_WRITE) && !w_fill;
  assign w_pix_hs    = o_pix_ready && i_pix_valid;

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_sel   = r_mem_sel;

  // Fill walks the clipped region; stream walks the full w x h and drops off-screen pixels.
  assign w_gen_w    = w_fill ? r_ew : r_cmd.w;
  assign w_gen_h    = w_fill ? r_eh : r_cmd.h;
  assign w_gen_load = (r_state == ST_SETUP);
  assign w_gen_step = (r_state == ST_WRITE) && (w_fill ? !w_gen_last : w_pix_hs);

  fb_addr_gen #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .AW   (AW)
  ) u_addr_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_gen_load),
    .i_step     (w_gen_step),
    .i_base     (w_base),
    .i_x        (r_cmd.x),
    .i_y        (r_cmd.y),
    .i_w        (w_gen_w),
    .i_h        (w_gen_h),
    .o_addr     (w_gen_addr),
    .o_next_addr(w_gen_next),
    .o_inb      (w_gen_inb),
    .o_last     (w_gen_last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_color     <= '0;
      r_ew        <= '0;
      r_eh        <= '0;
      r_drain     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_sel   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_mem_we  <= 1'b0;
          r_mem_sel <= '0;
          if (i_cmd_valid) begin
            r_cmd.mode <= i_cmd_mode;
            r_cmd.x    <= i_cmd_x;
            r_cmd.y    <= i_cmd_y;
            r_cmd.w    <= i_cmd_w;
            r_cmd.h    <= i_cmd_h;
            r_color    <= i_cmd_color;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_ew <= min9(r_cmd.w, w_x_room);
          r_eh <= min9(r_cmd.h, w_y_room);
          if (w_fill) begin
            if (w_reject) begin
              r_state <= ST_DONE;
            end else begin
              // First fill pixel leaves here so writes are back-to-back from WRITE's first cycle.
              r_state     <= ST_WRITE;
              r_mem_we    <= 1'b1;
              r_mem_sel   <= '1;
              r_mem_addr  <= w_base;
              r_mem_wdata <= r_color;
            end
          end else begin
            r_state <= w_degen ? ST_DONE : ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_fill) begin
            if (w_gen_last) begin
              r_mem_we  <= 1'b0;
              r_mem_sel <= '0;
              r_state   <= ST_DONE;
            end else begin
              r_mem_we   <= 1'b1;
              r_mem_sel  <= '1;
              r_mem_addr <= w_gen_next;
            end
          end else if (w_pix_hs) begin
            r_mem_we  <= w_gen_inb;
            r_mem_sel <= {(DW/8){w_gen_inb}};
            if (w_gen_inb) begin
              r_mem_addr  <= w_gen_addr;
              r_mem_wdata <= i_pix_data;
            end
            if (w_gen_last) begin
              r_state <= ST_DONE;
              r_drain <= 1'b1;
            end
          end else begin
            r_mem_we  <= 1'b0;
            r_mem_sel <= '0;
          end
        end
        ST_DONE: begin
          r_mem_we  <= 1'b0;
          r_mem_sel <= '0;
          if (r_drain) begin
            r_drain <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: fill, clipping, rejects, streaming and mid-command reset.
module tb_fb_writer;
  import fb_pkg::*;

  localparam int DW = 24;
  localparam int AW = 15;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic          i_cmd_mode = 1'b0;
  logic [7:0]    i_cmd_x = '0;
  logic [7:0]    i_cmd_y = '0;
  logic [8:0]    i_cmd_w = '0;
  logic [8:0]    i_cmd_h = '0;
  logic [DW-1:0] i_cmd_color = '0;
  logic          i_pix_valid = 1'b0;
  logic          o_pix_ready;
  logic [DW-1:0] i_pix_data = '0;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [2:0]    o_mem_sel;
  logic          o_mem_we;
  logic          o_busy;
  logic          o_done;

  always #5 i_clk = ~i_clk;

  fb_writer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_mode(i_cmd_mode),
    .i_cmd_x(i_cmd_x), .i_cmd_y(i_cmd_y), .i_cmd_w(i_cmd_w), .i_cmd_h(i_cmd_h),
    .i_cmd_color(i_cmd_color),
    .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready), .i_pix_data(i_pix_data),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_sel(o_mem_sel),
    .o_mem_we(o_mem_we), .o_busy(o_busy), .o_done(o_done)
  );

  int checks = 0;
  int failures = 0;

  logic          log_we    [0:63];
  logic [AW-1:0] log_addr  [0:63];
  logic [DW-1:0] log_data  [0:63];
  logic [2:0]    log_sel   [0:63];
  logic          log_done  [0:63];
  logic          log_cready[0:63];
  logic          log_pready[0:63];
  bit            sched     [0:63];
  logic [DW-1:0] pix_q     [0:15];
  int            n_pix;
  int            n_consumed;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 64; i++) sched[i] = 1'b0;
    n_pix = 0;
  endtask

  // Waits for cmd_ready, handshakes in cycle t, returns in cycle t+1.
  task automatic issue_cmd(input logic mode, input logic [7:0] x, input logic [7:0] y,
                           input logic [8:0] w, input logic [8:0] h, input logic [DW-1:0] color);
    int n;
    n = 0;
    while (!o_cmd_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_timeout got=%0b exp=1", o_cmd_ready);
    end
    i_cmd_valid = 1'b1;
    i_cmd_mode  = mode;
    i_cmd_x     = x;
    i_cmd_y     = y;
    i_cmd_w     = w;
    i_cmd_h     = h;
    i_cmd_color = color;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  // Logs outputs of cycles t+1..t+L and offers stream pixels on scheduled cycles.
  task automatic run_cycles(input int len);
    n_consumed = 0;
    for (int c = 1; c <= len; c++) begin
      log_we[c]     = o_mem_we;
      log_addr[c]   = o_mem_addr;
      log_data[c]   = o_mem_wdata;
      log_sel[c]    = o_mem_sel;
      log_done[c]   = o_done;
      log_cready[c] = o_cmd_ready;
      log_pready[c] = o_pix_ready;
      if (sched[c] && n_consumed < n_pix) begin
        i_pix_valid = 1'b1;
        i_pix_data  = pix_q[n_consumed];
        if (o_pix_ready) n_consumed++;
      end else begin
        i_pix_valid = 1'b0;
      end
      tick();
    end
    i_pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (o_mem_we !== 1'b0)    begin failures++; $display("FAIL rst_we got=%0b exp=0", o_mem_we); end
    checks++; if (o_mem_addr !== '0)    begin failures++; $display("FAIL rst_addr got=%0d exp=0", o_mem_addr); end
    checks++; if (o_mem_wdata !== '0)   begin failures++; $display("FAIL rst_wdata got=%0h exp=0", o_mem_wdata); end
    checks++; if (o_mem_sel !== 3'b000) begin failures++; $display("FAIL rst_sel got=%0b exp=000", o_mem_sel); end
    checks++; if (o_busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%0b exp=0", o_busy); end
    checks++; if (o_done !== 1'b0)      begin failures++; $display("FAIL rst_done got=%0b exp=0", o_done); end
    checks++; if (o_pix_ready !== 1'b0) begin failures++; $display("FAIL rst_pix_ready got=%0b exp=0", o_pix_ready); end
    checks++; if (o_cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%0b exp=1", o_cmd_ready); end
  endtask

  task automatic test_fill_2x2();
    logic [AW-1:0] ea [4];
    logic          exp_we;
    ea = '{15'd0, 15'd1, 15'd135, 15'd136};
    clear_sched();
    issue_cmd(MODE_FILL, 8'd0, 8'd0, 9'd2, 9'd2, 24'hFF0000);
    run_cycles(8);
    for (int c = 1; c <= 7; c++) begin
      exp_we = (c >= 2 && c <= 5);
      checks++;
      if (log_we[c] !== exp_we) begin failures++; $display("FAIL fill2_we c=%0d got=%0b exp=%0b", c, log_we[c], exp_we); end
      if (exp_we) begin
        checks++;
        if (log_addr[c] !== ea[c-2]) begin failures++; $display("FAIL fill2_addr c=%0d got=%0d exp=%0d", c, log_addr[c], ea[c-2]); end
        checks++;
        if (log_data[c] !== 24'hFF0000) begin failures++; $display("FAIL fill2_data c=%0d got=%0h exp=ff0000", c, log_data[c]); end
        checks++;
        if (log_sel[c] !== 3'b111) begin failures++; $display("FAIL fill2_sel c=%0d got=%0b exp=111", c, log_sel[c]); end
      end else begin
        checks++;
        if (log_sel[c] !== 3'b000) begin failures++; $display("FAIL fill2_sel_idle c=%0d got=%0b exp=000", c, log_sel[c]); end
      end
      checks++;
      if (log_done[c] !== (c == 6)) begin failures++; $display("FAIL fill2_done c=%0d got=%0b exp=%0b", c, log_done[c], (c == 6)); end
      checks++;
      if (log_cready[c] !== (c == 7)) begin failures++; $display("FAIL fill2_cmd_ready c=%0d got=%0b exp=%0b", c, log_cready[c], (c == 7)); end
    end
  endtask

  task automatic test_fill_clip();
    logic [AW-1:0] ea [10];
    int            idx;
    ea = '{15'd32260, 15'd32261, 15'd32262, 15'd32263, 15'd32264,
           15'd32395, 15'd32396, 15'd32397, 15'd32398, 15'd32399};
    clear_sched();
    issue_cmd(MODE_FILL, 8'd130, 8'd238, 9'd10, 9'd5, 24'h00FF00);
    run_cycles(14);
    idx = 0;
    for (int c = 1; c <= 13; c++) begin
      if (log_we[c]) begin
        if (idx < 10) begin
          checks++;
          if (log_addr[c] !== ea[idx]) begin failures++; $display("FAIL clip_addr n=%0d got=%0d exp=%0d", idx, log_addr[c], ea[idx]); end
        end
        checks++;
        if (log_addr[c] >= 15'd32400) begin failures++; $display("FAIL clip_range n=%0d got=%0d exp=<32400", idx, log_addr[c]); end
        idx++;
      end
      checks++;
      if (log_done[c] !== (c == 12)) begin failures++; $display("FAIL clip_done c=%0d got=%0b exp=%0b", c, log_done[c], (c == 12)); end
    end
    checks++;
    if (idx !== 10) begin failures++; $display("FAIL clip_count got=%0d exp=10", idx); end
  endtask

  task automatic test_fill_reject();
    for (int s = 0; s < 2; s++) begin
      clear_sched();
      if (s == 0) issue_cmd(MODE_FILL, 8'd3, 8'd3, 9'd0, 9'd4, 24'h123456);
      else        issue_cmd(MODE_FILL, 8'd135, 8'd3, 9'd4, 9'd4, 24'h123456);
      run_cycles(4);
      for (int c = 1; c <= 3; c++) begin
        checks++;
        if (log_we[c] !== 1'b0) begin failures++; $display("FAIL reject%0d_we c=%0d got=%0b exp=0", s, c, log_we[c]); end
        checks++;
        if (log_done[c] !== (c == 2)) begin failures++; $display("FAIL reject%0d_done c=%0d got=%0b exp=%0b", s, c, log_done[c], (c == 2)); end
        checks++;
        if (log_cready[c] !== (c == 3)) begin failures++; $display("FAIL reject%0d_cmd_ready c=%0d got=%0b exp=%0b", s, c, log_cready[c], (c == 3)); end
      end
    end
  endtask

  task automatic test_stream_gaps();
    logic [DW-1:0] ed [3];
    logic          exp_we;
    ed = '{24'h112233, 24'h445566, 24'h778899};
    clear_sched();
    sched[2] = 1'b1; sched[4] = 1'b1; sched[6] = 1'b1;
    pix_q[0] = 24'h112233; pix_q[1] = 24'h445566; pix_q[2] = 24'h778899;
    n_pix = 3;
    issue_cmd(MODE_STREAM, 8'd10, 8'd0, 9'd3, 9'd1, 24'h0);
    run_cycles(10);
    for (int c = 1; c <= 9; c++) begin
      exp_we = (c == 3 || c == 5 || c == 7);
      checks++;
      if (log_we[c] !== exp_we) begin failures++; $display("FAIL stream_we c=%0d got=%0b exp=%0b", c, log_we[c], exp_we); end
      if (exp_we) begin
        checks++;
        if (log_addr[c] !== AW'(10 + (c - 3) / 2)) begin failures++; $display("FAIL stream_addr c=%0d got=%0d exp=%0d", c, log_addr[c], 10 + (c - 3) / 2); end
        checks++;
        if (log_data[c] !== ed[(c - 3) / 2]) begin failures++; $display("FAIL stream_data c=%0d got=%0h exp=%0h", c, log_data[c], ed[(c - 3) / 2]); end
      end
      checks++;
      if (log_done[c] !== (c == 8)) begin failures++; $display("FAIL stream_done c=%0d got=%0b exp=%0b", c, log_done[c], (c == 8)); end
      checks++;
      if (log_pready[c] !== (c >= 2 && c <= 6)) begin failures++; $display("FAIL stream_pix_ready c=%0d got=%0b exp=%0b", c, log_pready[c], (c >= 2 && c <= 6)); end
    end
    checks++;
    if (n_consumed !== 3) begin failures++; $display("FAIL stream_consumed got=%0d exp=3", n_consumed); end
  endtask

  task automatic test_stream_clip();
    clear_sched();
    sched[2] = 1'b1; sched[3] = 1'b1;
    pix_q[0] = 24'hABCDEF; pix_q[1] = 24'h123456;
    n_pix = 2;
    issue_cmd(MODE_STREAM, 8'd134, 8'd0, 9'd2, 9'd1, 24'h0);
    run_cycles(8);
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (log_we[c] !== (c == 3)) begin failures++; $display("FAIL sclip_we c=%0d got=%0b exp=%0b", c, log_we[c], (c == 3)); end
      checks++;
      if (log_done[c] !== (c == 5)) begin failures++; $display("FAIL sclip_done c=%0d got=%0b exp=%0b", c, log_done[c], (c == 5)); end
    end
    checks++;
    if (log_addr[3] !== 15'd134) begin failures++; $display("FAIL sclip_addr got=%0d exp=134", log_addr[3]); end
    checks++;
    if (log_data[3] !== 24'hABCDEF) begin failures++; $display("FAIL sclip_data got=%0h exp=abcdef", log_data[3]); end
    checks++;
    if (n_consumed !== 2) begin failures++; $display("FAIL sclip_consumed got=%0d exp=2", n_consumed); end
  endtask

  task automatic test_stream_offscreen();
    clear_sched();
    for (int c = 2; c <= 5; c++) sched[c] = 1'b1;
    pix_q[0] = 24'h1; pix_q[1] = 24'h2; pix_q[2] = 24'h3; pix_q[3] = 24'h4;
    n_pix = 4;
    issue_cmd(MODE_STREAM, 8'd200, 8'd0, 9'd2, 9'd2, 24'h0);
    run_cycles(9);
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (log_we[c] !== 1'b0) begin failures++; $display("FAIL soff_we c=%0d got=%0b exp=0", c, log_we[c]); end
      checks++;
      if (log_done[c] !== (c == 7)) begin failures++; $display("FAIL soff_done c=%0d got=%0b exp=%0b", c, log_done[c], (c == 7)); end
    end
    checks++;
    if (n_consumed !== 4) begin failures++; $display("FAIL soff_consumed got=%0d exp=4", n_consumed); end
  endtask

  task automatic test_reset_mid();
    int nw;
    clear_sched();
    issue_cmd(MODE_FILL, 8'd0, 8'd0, 9'd4, 9'd4, 24'h0000FF);
    run_cycles(4);
    nw = 0;
    for (int c = 2; c <= 4; c++) if (log_we[c]) nw++;
    checks++;
    if (nw !== 3) begin failures++; $display("FAIL rmid_prewrites got=%0d exp=3", nw); end
    i_rst = 1'b1;
    #1;
    checks++; if (o_mem_we !== 1'b0)    begin failures++; $display("FAIL rmid_we got=%0b exp=0", o_mem_we); end
    checks++; if (o_busy !== 1'b0)      begin failures++; $display("FAIL rmid_busy got=%0b exp=0", o_busy); end
    checks++; if (o_cmd_ready !== 1'b1) begin failures++; $display("FAIL rmid_cmd_ready got=%0b exp=1", o_cmd_ready); end
    checks++; if (o_mem_addr !== '0)    begin failures++; $display("FAIL rmid_addr got=%0d exp=0", o_mem_addr); end
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    issue_cmd(MODE_FILL, 8'd5, 8'd5, 9'd1, 9'd1, 24'h00AA00);
    run_cycles(5);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (log_we[c] !== (c == 2)) begin failures++; $display("FAIL rmid_new_we c=%0d got=%0b exp=%0b", c, log_we[c], (c == 2)); end
      checks++;
      if (log_done[c] !== (c == 3)) begin failures++; $display("FAIL rmid_new_done c=%0d got=%0b exp=%0b", c, log_done[c], (c == 3)); end
    end
    checks++;
    if (log_addr[2] !== 15'd680) begin failures++; $display("FAIL rmid_new_addr got=%0d exp=680", log_addr[2]); end
    checks++;
    if (log_data[2] !== 24'h00AA00) begin failures++; $display("FAIL rmid_new_data got=%0h exp=00aa00", log_data[2]); end
  endtask

  initial begin
    clear_sched();
    i_rst = 1'b1;
    tick();
    tick();
    test_reset();
    i_rst = 1'b0;
    tick();
    test_reset();
    test_fill_2x2();
    test_fill_clip();
    test_fill_reject();
    test_stream_gaps();
    test_stream_clip();
    test_stream_offscreen();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
# fb_writer

Rectangle writer for the SPI-LCD framebuffer, the write side of the 135×240 BRAM that the display engine scans out. It accepts one rectangle command at a time. It either fills the rectangle with a solid colour or writes an incoming pixel stream into it, row-major, and drives the BRAM write port (addr/wdata/sel/we). Pixels outside the screen are clipped.

## Interface
- H_RES, 135, screen width in pixels
- V_RES, 240, screen height in pixels
- DW, 24, pixel width (RGB888)
- AW, $clog2(H_RES*V_RES) = 15, framebuffer address width
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both are high
- cmd_mode  in  1  0 = FILL, 1 = STREAM
- cmd_x, cmd_y  in  8 each  top-left corner
- cmd_w, cmd_h  in  9 each  size in pixels
- cmd_color  in  DW  fill colour (FILL only)
- pix_valid  in  1  stream pixel offered
- pix_ready  out  1  stream pixel accepted when both are high
- pix_data  in  DW  stream pixel
- mem_addr  out  AW  BRAM address
- mem_wdata  out  DW  BRAM write data
- mem_sel  out  DW/8  byte select: all ones while mem_we=1, else 0
- mem_we  out  1  write strobe; one pixel per cycle
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE → SETUP → WRITE → DONE → IDLE.
- IDLE: cmd_ready=1. On handshake, register the command and go to SETUP.
- SETUP, one cycle:
  - Compute base = y*H_RES + x with one registered multiply.
  - Compute clipped ew = min(w, H_RES−x) and eh = min(h, V_RES−y).
  - Reject condition: x≥H_RES, y≥V_RES, w=0 or h=0.
  - FILL and rejected: go to DONE. Otherwise go to WRITE.
- WRITE, FILL: iterate the clipped ew×eh region, writing cmd_color.
- WRITE, STREAM:
  - pix_ready=1. Each handshake advances the column and row counters over the original w×h.
  - A pixel is written only if (x+col)<H_RES and (y+row)<V_RES. Otherwise it is consumed and dropped.
  - STREAM with w=0 or h=0 goes to DONE with nothing consumed.
  - STREAM with x or y off-screen consumes all w·h pixels and writes none.
- Addressing is incremental, with no per-pixel multiply:
  - mem_addr = row_base + col.
  - At the end of a row: col←0, row_base += H_RES.
- DONE: done=1 for one cycle, then return to IDLE.
- Reset (any time, including mid-command): abandon the command and go to IDLE.
  - Reset values: mem_we=0, mem_addr=0, mem_wdata=0, mem_sel=0, busy=0, done=0, pix_ready=0, cmd_ready=1.

## Timing
- Command accepted in cycle t: SETUP in t+1, WRITE from t+2.
- FILL with N = ew·eh writes: mem_we=1 in cycles t+2 … t+N+1, back-to-back; done in cycle t+N+2; cmd_ready=1 from t+N+3.
- Rejected or degenerate command: done in cycle t+2.
- STREAM: pixel handshake in cycle s → its mem_we (if in-bounds) in cycle s+1. The last handshake in s gives done in s+2.
- pix_valid gaps stall the engine without losing position. pix_ready stays high throughout WRITE; it is not throttled.
- mem_* outputs are registered. mem_addr and mem_wdata are don't-care when mem_we=0, but they hold their last value.
- cmd_ready=0 whenever busy=1. Commands offered while busy are not accepted.

## Structure
- Shared package fb_pkg holds:
  - H_RES and V_RES defaults.
  - Mode encodings MODE_FILL=0 and MODE_STREAM=1.
  - State encoding.
  - The AW derivation.
- One sub-module, fb_addr_gen, holds the col/row counters, row_base accumulation, in-bounds flag and last-pixel flag. It is advanced by a single step input.
- The top level keeps the FSM, command registers, SETUP arithmetic and mem_* output registers.

## Test plan
- FILL x=0 y=0 w=2 h=2 colour 0xFF0000, accepted in t: writes to addresses 0, 1, 135, 136 in t+2..t+5, data 0xFF0000, sel=3'b111; done in t+6.
- FILL x=130 y=238 w=10 h=5: exactly 10 writes, addresses 32260–32264 then 32395–32399; no address ≥32400.
- FILL w=0, and separately x=135: no mem_we; done in t+2; next command accepted in t+3.
- STREAM x=10 y=0 w=3 h=1, pixels A, B, C with one idle cycle between each: writes addresses 10, 11, 12 with A, B, C, each one cycle after its handshake; done two cycles after C.
- STREAM x=134 y=0 w=2 h=1: two pixels consumed, one write (address 134, first pixel); done follows.
- rst asserted mid-FILL (after 3 writes of a 4×4 fill): mem_we=0 and busy=0 immediately; after release, a new 1×1 FILL at (5,5) writes address 680 only.
